dffsr_pipe: RTL and testbench
=============================

Name: dffsr_pipe

Overview:
- Parametrised successor to the single-bit set/reset flip-flop cell: a WIDTH-bit, DEPTH-stage elastic pipeline register.
- Provides a valid/ready handshake, per-stage bubble collapsing, synchronous flush and preset, and an occupancy counter.
- Used as the standard retiming and buffering register between SoC-flow blocks, in place of hand-chained DFFSR cells.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of pipeline stages (>=1).
- RST_VAL, 0, value every data register takes on asynchronous reset (WIDTH bits).
- SET_VAL, all-ones, value loaded into every data register by PRESET (WIDTH bits).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- R  in  1  reset, asynchronous, active-low; clears all state immediately, released synchronously by the integrator.
- IN_VALID  in  1  upstream word valid.
- IN_READY  out  1  pipeline can accept a word this cycle.
- IN_DATA  in  WIDTH  upstream word.
- OUT_VALID  out  1  last stage holds a valid word.
- OUT_READY  in  1  downstream accepts a word this cycle.
- OUT_DATA  out  WIDTH  last-stage data register (registered output).
- FLUSH  in  1  synchronous: discard all words.
- PRESET  in  1  synchronous: fill the pipeline with SET_VAL.
- OCC  out  $clog2(DEPTH+1)  registered count of valid stages.

Behaviour:
- Reset (R=0, asynchronous):
  - every data register = RST_VAL;
  - every valid bit = 0, so OUT_VALID = 0;
  - OCC = 0.
  - IN_READY = 1 as soon as R = 1.
- Stage i holds data[i] and v[i]; stage 0 is the input, stage DEPTH-1 is the output.
- Advance rules:
  - adv[DEPTH-1] = v[DEPTH-1] & OUT_READY.
  - adv[i] = v[i] & (~v[i+1] | adv[i+1]).
  - Stage i+1 loads data[i] when adv[i]; v[i] clears when it advances and nothing refills it.
- Input side:
  - IN_READY = ~v[0] | adv[0] (combinational from OUT_READY, with no registered skid).
  - A word is accepted when IN_VALID & IN_READY; it is loaded into stage 0 and sets v[0].
- Output and latency:
  - OUT_VALID = v[DEPTH-1]; OUT_DATA = data[DEPTH-1].
  - Latency with no stalls: a word accepted at edge t is presented at OUT after edge t+DEPTH-1, i.e. DEPTH registers.
  - Throughput is 1 word/cycle when OUT_READY is held high.
- Full and empty:
  - All v = 1 with OUT_READY = 0 gives IN_READY = 0.
  - A full pipeline with OUT_READY = 1 accepts and emits in the same cycle; OCC is unchanged.
  - Empty: OUT_VALID = 0, and OUT_DATA holds its last value (don't-care).
- OCC:
  - +1 on accept only; -1 on emit only; unchanged on both or neither.
  - Never exceeds DEPTH; never goes below 0.
- FLUSH = 1:
  - all v = 0 and OCC = 0 next cycle; data registers unchanged;
  - IN_READY forced to 0 that cycle (no accept); OUT_VALID unaffected combinationally (the word in flight can still handshake).
  - OCC = 0 regardless of any emit that cycle.
- PRESET = 1:
  - all data = SET_VAL, all v = 1, OCC = DEPTH next cycle;
  - IN_READY forced to 0 that cycle.
- Simultaneous events:
  - FLUSH and PRESET together: FLUSH wins.
  - R low dominates everything.
- Reset mid-operation: in-flight words are lost; no partial handshake survives.

Optional Feature:
- Macro: DFFSR_PIPE_SCAN_EN.
- When defined, adds three ports: SCAN_EN in 1, SCAN_IN in 1, SCAN_OUT out 1.
- SCAN_EN = 1:
  - all DEPTH*WIDTH data bits shift one position per CLK, from stage 0 bit 0 towards stage DEPTH-1 bit WIDTH-1;
  - SCAN_IN feeds stage 0 bit 0; SCAN_OUT = data[DEPTH-1][WIDTH-1];
  - valid bits and OCC hold; IN_READY = 0 and OUT_VALID = 0;
  - FLUSH and PRESET are ignored.
- When not defined: the scan ports are absent and there is no scan mux in the data path.

Decomposition:
- Package dffsr_pipe_pkg:
  - occupancy width function occ_w(depth) = $clog2(depth+1);
  - default RST_VAL/SET_VAL constants.
- Sub-module dffsr_pipe_stage: one data register plus valid bit, async clear, load/preset/flush/scan muxing. It is instantiated DEPTH times by a generate loop; the top holds the advance chain and OCC.

Test Plan:
- Reset then stream: WIDTH=8, DEPTH=4, R pulsed low mid-stream -> all outputs reset at once (OUT_VALID=0, OCC=0, OUT_DATA=0x00). After release, send 0x01..0x08 with OUT_READY=1 -> 0x01 appears after 4 edges, then one word per cycle, OCC steady at 4.
- Backpressure: fill with 0xA0..0xA3 while OUT_READY=0 -> IN_READY=0 and OCC=4. Then set OUT_READY=1 together with IN_VALID=1 -> accept and emit in the same cycle, OCC stays 4, order preserved.
- Bubble collapse: one word into an empty pipe, OUT_READY=0 -> word sits in stage 3, IN_READY stays 1, three more words fill stages 2..0, OCC=4.
- FLUSH with OCC=3 and IN_VALID=1 -> no accept; next cycle OCC=0, OUT_VALID=0. FLUSH and PRESET together -> flush result.
- PRESET with SET_VAL=0xFF -> next cycle OCC=4; four 0xFF words drain with OUT_READY=1.
- DFFSR_PIPE_SCAN_EN defined: shift 32 bits 1,0,1,1,... through the chain -> SCAN_OUT reproduces the pattern after 32 clocks, v/OCC unchanged.

Source files
------------

// File: rtl/dffsr_pipe_pkg.sv
// Shared constants, stage-operation encoding and the occupancy-width helper for dffsr_pipe.
package dffsr_pipe_pkg;

    localparam logic DEF_RST_BIT = 1'b0;
    localparam logic DEF_SET_BIT = 1'b1;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_DRAIN,
        OP_FLUSH,
        OP_PRESET,
        OP_SCAN
    } stage_op_e;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dffsr_pipe_stage.sv
// One pipeline stage: data register plus valid bit with load/drain/flush/preset control.
// Scan shifting is compiled in only when DFFSR_PIPE_SCAN_EN is defined.
module dffsr_pipe_stage
    import dffsr_pipe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic             flush_i,
    input  logic             preset_i,
    input  logic [WIDTH-1:0] din_i,
`ifdef DFFSR_PIPE_SCAN_EN
    input  logic             scan_en_i,
    input  logic             scan_in_i,
`endif
    output logic [WIDTH-1:0] data_o,
    output logic             v_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             v_q, v_d;
    stage_op_e        op;

    // A refill from upstream wins over draining, so a stage that advances
    // and is reloaded in the same cycle stays valid.
    always_comb begin
        op = OP_HOLD;
        if (flush_i)       op = OP_FLUSH;
        else if (preset_i) op = OP_PRESET;
        else if (load_i)   op = OP_LOAD;
        else if (adv_i)    op = OP_DRAIN;
`ifdef DFFSR_PIPE_SCAN_EN
        if (scan_en_i)     op = OP_SCAN;
`endif
    end

    always_comb begin
        data_d = data_q;
        v_d    = v_q;
        case (op)
            OP_LOAD: begin
                data_d = din_i;
                v_d    = 1'b1;
            end
            OP_DRAIN:  v_d = 1'b0;
            OP_FLUSH:  v_d = 1'b0;
            OP_PRESET: begin
                data_d = SET_VAL;
                v_d    = 1'b1;
            end
`ifdef DFFSR_PIPE_SCAN_EN
            OP_SCAN:   data_d = (data_q << 1) | WIDTH'(scan_in_i);
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= RST_VAL;
            v_q    <= 1'b0;
        end else begin
            data_q <= data_d;
            v_q    <= v_d;
        end
    end

    assign data_o = data_q;
    assign v_o    = v_q;

endmodule

// File: rtl/dffsr_pipe.sv
// WIDTH-bit, DEPTH-stage elastic pipeline register with valid/ready, bubble collapse,
// flush, preset and occupancy count. Define DFFSR_PIPE_SCAN_EN to add the scan chain ports.
module dffsr_pipe
    import dffsr_pipe_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEF_RST_BIT}},
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{DEF_SET_BIT}}
) (
    input  logic                    CLK,
    input  logic                    R,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [WIDTH-1:0]        IN_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [WIDTH-1:0]        OUT_DATA,
    input  logic                    FLUSH,
    input  logic                    PRESET,
`ifdef DFFSR_PIPE_SCAN_EN
    input  logic                    SCAN_EN,
    input  logic                    SCAN_IN,
    output logic                    SCAN_OUT,
`endif
    output logic [occ_w(DEPTH)-1:0] OCC
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic                        scan;
    logic                        flush_eff, preset_eff;
    logic                        accept, emit;
    logic [OCC_W-1:0]            occ_q, occ_d;

`ifdef DFFSR_PIPE_SCAN_EN
    assign scan     = SCAN_EN;
    assign SCAN_OUT = data[DEPTH-1][WIDTH-1];
`else
    assign scan     = 1'b0;
`endif

    assign flush_eff  = FLUSH & ~scan;
    assign preset_eff = PRESET & ~FLUSH & ~scan;

    // Ripple from the output back: a stage moves if the next one is empty or moving.
    always_comb begin
        logic [DEPTH-1:0] a;
        a            = '0;
        a[DEPTH-1]   = v[DEPTH-1] & OUT_READY & ~scan;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            a[i] = v[i] & (~v[i+1] | a[i+1]);
        end
        adv = a;
    end

    assign IN_READY  = (~v[0] | adv[0]) & ~FLUSH & ~PRESET & ~scan;
    assign accept    = IN_VALID & IN_READY;
    assign OUT_VALID = v[DEPTH-1] & ~scan;
    assign OUT_DATA  = data[DEPTH-1];
    assign emit      = OUT_VALID & OUT_READY;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] din;
`ifdef DFFSR_PIPE_SCAN_EN
        logic             sin;
`endif
        if (i == 0) begin : g_head
            assign din     = IN_DATA;
            assign load[i] = accept;
`ifdef DFFSR_PIPE_SCAN_EN
            assign sin     = SCAN_IN;
`endif
        end else begin : g_body
            assign din     = data[i-1];
            assign load[i] = adv[i-1];
`ifdef DFFSR_PIPE_SCAN_EN
            assign sin     = data[i-1][WIDTH-1];
`endif
        end

        dffsr_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL),
            .SET_VAL (SET_VAL)
        ) u_stage (
            .clk_i     (CLK),
            .rst_ni    (R),
            .load_i    (load[i]),
            .adv_i     (adv[i]),
            .flush_i   (flush_eff),
            .preset_i  (preset_eff),
            .din_i     (din),
`ifdef DFFSR_PIPE_SCAN_EN
            .scan_en_i (scan),
            .scan_in_i (sin),
`endif
            .data_o    (data[i]),
            .v_o       (v[i])
        );
    end

    always_comb begin
        occ_d = occ_q;
        if (!scan) begin
            if (FLUSH)       occ_d = '0;
            else if (PRESET) occ_d = OCC_W'(DEPTH);
            else             occ_d = occ_q + OCC_W'(accept) - OCC_W'(emit);
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) occ_q <= '0;
        else    occ_q <= occ_d;
    end

    assign OCC = occ_q;

endmodule

// File: tb/tb_dffsr_pipe.sv
// Directed scoreboard bench for dffsr_pipe (WIDTH=8, DEPTH=4); scan test runs when DFFSR_PIPE_SCAN_EN is defined.
module tb_dffsr_pipe;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int OW = $clog2(D + 1);

    logic          CLK = 1'b0;
    logic          R = 1'b1;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [W-1:0]  IN_DATA = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [W-1:0]  OUT_DATA;
    logic          FLUSH = 1'b0;
    logic          PRESET = 1'b0;
    logic [OW-1:0] OCC;
`ifdef DFFSR_PIPE_SCAN_EN
    logic          SCAN_EN = 1'b0;
    logic          SCAN_IN = 1'b0;
    logic          SCAN_OUT;
    logic [31:0]   pat = 32'h5A3C_96CD;
`endif

    int            n_chk = 0;
    int            n_pass = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  mon_exp;

    dffsr_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK       (CLK),
        .R         (R),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .FLUSH     (FLUSH),
        .PRESET    (PRESET),
`ifdef DFFSR_PIPE_SCAN_EN
        .SCAN_EN   (SCAN_EN),
        .SCAN_IN   (SCAN_IN),
        .SCAN_OUT  (SCAN_OUT),
`endif
        .OCC       (OCC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Holds IN_VALID until the word is taken; expected output is queued at that point.
    task automatic send(input logic [W-1:0] d);
        bit ok;
        ok       = 1'b0;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        for (int w = 0; w < 40 && !ok; w++) begin
            @(negedge CLK);
            if (IN_READY) begin
                exp_q.push_back(d);
                ok = 1'b1;
            end
        end
        chk("send_accept", 32'(ok), 32'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (R && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL out_unexpected: got %0h, expected no word", OUT_DATA);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("out_data", 32'(OUT_DATA), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        #2 R = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_occ", 32'(OCC), 32'd0);
        chk("rst_out_data", 32'(OUT_DATA), 32'h00);
        R = 1'b1;
        #1 chk("rst_in_ready", 32'(IN_READY), 32'd1);

        // Fill with backpressure, then reset asynchronously mid-stream
        for (int k = 0; k < 4; k++) send(8'(8'h11 + k));
        chk("pre_rst_occ", 32'(OCC), 32'd4);
        chk("pre_rst_data", 32'(OUT_DATA), 32'h11);
        R = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("midrst_occ", 32'(OCC), 32'd0);
        chk("midrst_out_data", 32'(OUT_DATA), 32'h00);
        exp_q.delete();
        tick();
        R = 1'b1;

        // Streaming: first word after DEPTH registers, then one per cycle
        OUT_READY = 1'b1;
        #1;
        for (int j = 0; j < 8; j++) begin
            IN_VALID = 1'b1;
            IN_DATA  = 8'(j + 1);
            chk("stream_in_ready", 32'(IN_READY), 32'd1);
            exp_q.push_back(8'(j + 1));
            tick();
            chk("stream_out_valid", 32'(OUT_VALID), (j >= 3) ? 32'd1 : 32'd0);
            chk("stream_occ", 32'(OCC), (j >= 3) ? 32'd4 : 32'(j + 1));
        end
        IN_VALID = 1'b0;
        repeat (6) tick();
        chk("stream_drain_occ", 32'(OCC), 32'd0);
        chk("stream_drain_q", 32'(exp_q.size()), 32'd0);

        // Bubble collapse then backpressure
        OUT_READY = 1'b0;
        send(8'hA0);
        repeat (3) tick();
        chk("bubble_out_valid", 32'(OUT_VALID), 32'd1);
        chk("bubble_out_data", 32'(OUT_DATA), 32'hA0);
        chk("bubble_in_ready", 32'(IN_READY), 32'd1);
        chk("bubble_occ", 32'(OCC), 32'd1);
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        chk("full_occ", 32'(OCC), 32'd4);
        chk("full_in_ready", 32'(IN_READY), 32'd0);
        OUT_READY = 1'b1;
        #1 chk("full_ready_passthru", 32'(IN_READY), 32'd1);
        send(8'hA4);
        chk("full_accept_emit_occ", 32'(OCC), 32'd4);
        repeat (5) tick();
        chk("bp_drain_occ", 32'(OCC), 32'd0);

        // Flush with OCC=3 and a word offered
        OUT_READY = 1'b0;
        send(8'hB0);
        send(8'hB1);
        send(8'hB2);
        chk("flush_pre_occ", 32'(OCC), 32'd3);
        FLUSH    = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 8'hB3;
        #1 chk("flush_in_ready", 32'(IN_READY), 32'd0);
        tick();
        FLUSH    = 1'b0;
        IN_VALID = 1'b0;
        exp_q.delete();
        chk("flush_occ", 32'(OCC), 32'd0);
        chk("flush_out_valid", 32'(OUT_VALID), 32'd0);

        // Flush and preset together: flush wins
        send(8'hC0);
        FLUSH  = 1'b1;
        PRESET = 1'b1;
        tick();
        FLUSH  = 1'b0;
        PRESET = 1'b0;
        exp_q.delete();
        chk("fp_occ", 32'(OCC), 32'd0);
        chk("fp_out_valid", 32'(OUT_VALID), 32'd0);
        #1 chk("fp_in_ready", 32'(IN_READY), 32'd1);

        // Preset fills with SET_VAL, then drains
        PRESET = 1'b1;
        #1 chk("preset_in_ready", 32'(IN_READY), 32'd0);
        tick();
        PRESET = 1'b0;
        chk("preset_occ", 32'(OCC), 32'd4);
        chk("preset_out_valid", 32'(OUT_VALID), 32'd1);
        chk("preset_out_data", 32'(OUT_DATA), 32'hFF);
        repeat (4) exp_q.push_back(8'hFF);
        OUT_READY = 1'b1;
        repeat (4) tick();
        chk("preset_drain_occ", 32'(OCC), 32'd0);
        chk("preset_drain_q", 32'(exp_q.size()), 32'd0);

`ifdef DFFSR_PIPE_SCAN_EN
        OUT_READY = 1'b0;
        PRESET    = 1'b1;
        tick();
        PRESET    = 1'b0;
        SCAN_EN   = 1'b1;
        #1;
        chk("scan_in_ready", 32'(IN_READY), 32'd0);
        chk("scan_out_valid", 32'(OUT_VALID), 32'd0);
        for (int k = 0; k < 64; k++) begin
            SCAN_IN = (k < 32) ? pat[k] : 1'b0;
            FLUSH   = (k == 10);
            if (k >= 32) chk("scan_out", 32'(SCAN_OUT), 32'(pat[k-32]));
            tick();
        end
        FLUSH = 1'b0;
        chk("scan_occ_hold", 32'(OCC), 32'd4);
        SCAN_EN = 1'b0;
        #1;
        chk("scan_v_hold", 32'(OUT_VALID), 32'd1);
        chk("scan_data_zero", 32'(OUT_DATA), 32'h00);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
`endif

        repeat (2) tick();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
